// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, the
// sequencing counter width and the default phase lengths.
package rst_seq_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_LOCK_STABLE_CYCLES = 256;
    localparam int DEF_BUFR_CLR_CYCLES    = 4;
    localparam int DEF_IDELAY_RST_CYCLES  = 64;
    localparam int DEF_GAP_CYCLES         = 16;
    localparam int DEF_RDY_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_BUFR_CLR  = 3'd1,
        S_DLY_RST   = 3'd2,
        S_WAIT_RDY  = 3'd3,
        S_PHY_REL   = 3'd4,
        S_LINK_REL  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear
// to 0 on reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// Power-up reset sequencer: MMCM lock qualification, BUFR clear, IDELAYCTRL
// reset/ready, then staged PHY and link reset release.
// Optional RDY timeout/retry logic is built when RST_SEQ_TIMEOUT_EN is defined.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int BUFR_CLR_CYCLES    = DEF_BUFR_CLR_CYCLES,
    parameter int IDELAY_RST_CYCLES  = DEF_IDELAY_RST_CYCLES,
    parameter int GAP_CYCLES         = DEF_GAP_CYCLES,
    parameter int RDY_TIMEOUT_CYCLES = DEF_RDY_TIMEOUT_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mmcm_locked,
    input  logic       i_idelayctrl_rdy,
    output logic       o_bufr_clr,
    output logic       o_idelayctrl_rst,
    output logic       o_phy_rst,
    output logic       o_link_rst,
    output logic       o_ready,
    output logic       o_timeout,
    output logic [3:0] o_retry_cnt
);

    localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUFR_LD = CNT_W'(BUFR_CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLY_LD = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDY_LD  = CNT_W'(RDY_TIMEOUT_CYCLES - 1);

    logic lock_s;
    logic rdy_s;

    sync_2ff u_sync_lock (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_mmcm_locked),
        .o_q   (lock_s)
    );

    sync_2ff u_sync_rdy (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_idelayctrl_rdy),
        .o_q   (rdy_s)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bufr_clr_q, bufr_clr_d;
    logic             idly_rst_q, idly_rst_d;
    logic             phy_rst_q, phy_rst_d;
    logic             link_rst_q, link_rst_d;
    logic             ready_q, ready_d;
`ifdef RST_SEQ_TIMEOUT_EN
    logic             timeout_q, timeout_d;
    logic [3:0]       retry_q, retry_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef RST_SEQ_TIMEOUT_EN
        timeout_d = 1'b0;
        retry_d   = retry_q;
`endif
        // Lock loss overrides everything, including a simultaneous RDY loss.
        if (state_q != S_WAIT_LOCK && !lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = LOCK_LD;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = LOCK_LD;
                    end else if (cnt_q == '0) begin
                        state_d = S_BUFR_CLR;
                        cnt_d   = BUFR_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_BUFR_CLR: begin
                    if (cnt_q == '0) begin
                        state_d = S_DLY_RST;
                        cnt_d   = IDLY_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DLY_RST: begin
                    // The timeout load is harmless when the timeout is not built.
                    if (cnt_q == '0) begin
                        state_d = S_WAIT_RDY;
                        cnt_d   = RDY_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (rdy_s) begin
                        state_d = S_PHY_REL;
                        cnt_d   = GAP_LD;
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        state_d   = S_DLY_RST;
                        cnt_d     = IDLY_LD;
                        timeout_d = 1'b1;
                        retry_d   = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
`endif
                end
                S_PHY_REL: begin
                    if (!rdy_s) begin
                        state_d = S_DLY_RST;
                        cnt_d   = IDLY_LD;
                    end else if (cnt_q == '0) begin
                        state_d = S_LINK_REL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_LINK_REL: begin
                    if (!rdy_s) begin
                        state_d = S_DLY_RST;
                        cnt_d   = IDLY_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!rdy_s) begin
                        state_d = S_DLY_RST;
                        cnt_d   = IDLY_LD;
                    end
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = LOCK_LD;
                end
            endcase
        end

        // Outputs are a registered decode of the next state, so they line up with state_q.
        bufr_clr_d = (state_d == S_BUFR_CLR);
        idly_rst_d = (state_d == S_WAIT_LOCK) || (state_d == S_BUFR_CLR) ||
                     (state_d == S_DLY_RST);
        phy_rst_d  = !((state_d == S_PHY_REL) || (state_d == S_LINK_REL) ||
                       (state_d == S_DONE));
        link_rst_d = !((state_d == S_LINK_REL) || (state_d == S_DONE));
        ready_d    = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_WAIT_LOCK;
            cnt_q      <= LOCK_LD;
            bufr_clr_q <= 1'b0;
            idly_rst_q <= 1'b1;
            phy_rst_q  <= 1'b1;
            link_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bufr_clr_q <= bufr_clr_d;
            idly_rst_q <= idly_rst_d;
            phy_rst_q  <= phy_rst_d;
            link_rst_q <= link_rst_d;
            ready_q    <= ready_d;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timeout_q <= 1'b0;
            retry_q   <= 4'd0;
        end else begin
            timeout_q <= timeout_d;
            retry_q   <= retry_d;
        end
    end

    assign o_timeout   = timeout_q;
    assign o_retry_cnt = retry_q;
`else
    assign o_timeout   = 1'b0;
    assign o_retry_cnt = 4'd0;
`endif

    assign o_bufr_clr       = bufr_clr_q;
    assign o_idelayctrl_rst = idly_rst_q;
    assign o_phy_rst        = phy_rst_q;
    assign o_link_rst       = link_rst_q;
    assign o_ready          = ready_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus pushes expected output-change
// events (cycle, output vector); a monitor pops and compares on every change.
module tb_rst_sequencer;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       lock = 1'b0;
    logic       rdy  = 1'b0;
    logic       bufr_clr, idly_rst, phy_rst, link_rst, ready, timeout;
    logic [3:0] retry_cnt;

    rst_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .BUFR_CLR_CYCLES    (2),
        .IDELAY_RST_CYCLES  (4),
        .GAP_CYCLES         (3),
        .RDY_TIMEOUT_CYCLES (20)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_mmcm_locked    (lock),
        .i_idelayctrl_rdy (rdy),
        .o_bufr_clr       (bufr_clr),
        .o_idelayctrl_rst (idly_rst),
        .o_phy_rst        (phy_rst),
        .o_link_rst       (link_rst),
        .o_ready          (ready),
        .o_timeout        (timeout),
        .o_retry_cnt      (retry_cnt)
    );

    typedef struct {
        int         cyc;
        logic [9:0] v;
    } ev_t;

    ev_t        evq[$];
    int         cyc       = 0;
    int         n_chk     = 0;
    int         n_fail    = 0;
    int         exp_retry = 0;
    bit         mon_en    = 1'b0;
    logic [9:0] prev_v;
    logic [9:0] dut_v;

    assign dut_v = {bufr_clr, idly_rst, phy_rst, link_rst, ready, timeout, retry_cnt};

    function automatic logic [9:0] mk(logic b, logic i, logic p, logic l, logic r,
                                      logic t, logic [3:0] rc);
        return {b, i, p, l, r, t, rc};
    endfunction

    localparam logic [9:0] RESET_V = 10'b0111000000;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic ev(input int t, input logic [9:0] v);
        evq.push_back('{cyc: t, v: v});
    endtask

    task automatic nominal(input int c);
        logic [3:0] r;
        r = 4'(exp_retry);
        ev(c + 10, mk(1, 1, 1, 1, 0, 0, r));
        ev(c + 12, mk(0, 1, 1, 1, 0, 0, r));
        ev(c + 16, mk(0, 0, 1, 1, 0, 0, r));
        ev(c + 17, mk(0, 0, 0, 1, 0, 0, r));
        ev(c + 20, mk(0, 0, 0, 0, 0, 0, r));
        ev(c + 21, mk(0, 0, 0, 0, 1, 0, r));
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: ordering invariant every cycle, event compare on every output change.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_chk++;
                if ((!link_rst && phy_rst) || (!phy_rst && (idly_rst || bufr_clr))) begin
                    n_fail++;
                    $display("FAIL ordering at cycle %0d: outputs %b", cyc, dut_v);
                end
                if (evq.size() > 0 && evq[0].cyc < cyc) begin
                    e = evq.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL missed_event: expected %b at cycle %0d, outputs %b at cycle %0d",
                             e.v, e.cyc, dut_v, cyc);
                end
                if (dut_v !== prev_v) begin
                    n_chk++;
                    if (evq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_change at cycle %0d: got %b, expected %b",
                                 cyc, dut_v, prev_v);
                    end else begin
                        e = evq.pop_front();
                        if (e.cyc != cyc || e.v !== dut_v) begin
                            n_fail++;
                            $display("FAIL event: got %b at cycle %0d, expected %b at cycle %0d",
                                     dut_v, cyc, e.v, e.cyc);
                        end else begin
                            $display("event ok: cycle %0d outputs %b", cyc, dut_v);
                        end
                    end
                    prev_v = dut_v;
                end
            end
        end
    end

    initial begin
        int c;
        int r;
        int t;

        repeat (3) @(negedge clk);
        check("reset_outputs", dut_v, RESET_V);
        prev_v = RESET_V;
        mon_en = 1'b1;

        // Nominal bring-up
        lock = 1'b1;
        rdy  = 1'b1;
        rst  = 1'b0;
        c    = cyc;
        nominal(c);
        wait_to(c + 26);
        check("nominal_done", dut_v, mk(0, 0, 0, 0, 1, 0, 4'(exp_retry)));

        // Lock loss in S_DONE, then relock
        c    = cyc;
        lock = 1'b0;
        ev(c + 3, mk(0, 1, 1, 1, 0, 0, 4'(exp_retry)));
        wait_to(c + 5);
        lock = 1'b1;
        c    = cyc;
        nominal(c);
        wait_to(c + 26);

        // Lock glitch: 5 cycles high, 1 low, then high
        c    = cyc;
        lock = 1'b0;
        ev(c + 3, mk(0, 1, 1, 1, 0, 0, 4'(exp_retry)));
        wait_to(c + 6);
        lock = 1'b1;
        wait_to(c + 11);
        lock = 1'b0;
        wait_to(c + 12);
        lock = 1'b1;
        c    = cyc;
        nominal(c);
        wait_to(c + 26);

        // RDY loss in S_DONE, RDY held low
        c   = cyc;
        rdy = 1'b0;
        ev(c + 3, mk(0, 1, 1, 1, 0, 0, 4'(exp_retry)));
        ev(c + 7, mk(0, 0, 1, 1, 0, 0, 4'(exp_retry)));
`ifdef RST_SEQ_TIMEOUT_EN
        for (int n = 1; n <= 17; n++) begin
            t = c + 27 + 24 * (n - 1);
            r = (n > 15) ? 15 : n;
            ev(t,     mk(0, 1, 1, 1, 0, 1, 4'(r)));
            ev(t + 1, mk(0, 1, 1, 1, 0, 0, 4'(r)));
            ev(t + 4, mk(0, 0, 1, 1, 0, 0, 4'(r)));
        end
        exp_retry = 15;
        wait_to(c + 27 + 24 * 16 + 5);
`else
        wait_to(c + 7 + 1000);
        check("wait_rdy_hold", dut_v, mk(0, 0, 1, 1, 0, 0, 4'd0));
`endif
        rdy = 1'b1;
        c   = cyc;
        ev(c + 3, mk(0, 0, 0, 1, 0, 0, 4'(exp_retry)));
        ev(c + 6, mk(0, 0, 0, 0, 0, 0, 4'(exp_retry)));
        ev(c + 7, mk(0, 0, 0, 0, 1, 0, 4'(exp_retry)));
        wait_to(c + 10);

        // Async reset pulse during S_PHY_REL
        c   = cyc;
        rdy = 1'b0;
        ev(c + 3, mk(0, 1, 1, 1, 0, 0, 4'(exp_retry)));
        wait_to(c + 1);
        rdy = 1'b1;
        ev(c + 7, mk(0, 0, 1, 1, 0, 0, 4'(exp_retry)));
        ev(c + 8, mk(0, 0, 0, 1, 0, 0, 4'(exp_retry)));
        wait_to(c + 9);
        ev(c + 10, RESET_V);
        exp_retry = 0;
        #2 rst = 1'b1;
        #1 check("async_reset", dut_v, RESET_V);
        wait_to(c + 12);
        rst = 1'b0;
        c   = cyc;
        nominal(c);
        wait_to(c + 26);

        for (int i = 0; i < 100 && evq.size() > 0; i++) @(negedge clk);
        n_chk++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected events outstanding, required 0", evq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
